// File: rtl/chan_arb_pkg.sv
// Shared defaults and helpers for the channel arbiter slice.
package chan_arb_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MAX_BURST = 4;

    // Width of a requester index; never narrower than one bit.
    function automatic int id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chan_arbiter_rr_pick.sv
// Combinational round-robin search: first eligible index at or after start, wrapping.
module rr_pick
    import chan_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int ID_W  = id_w(DEF_N_REQ)
) (
    input  logic [N_REQ-1:0] eligible,
    input  logic [ID_W-1:0]  start,
    output logic [N_REQ-1:0] grant,
    output logic             found
);

    logic [ID_W-1:0] idx;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((int'(start) + k) % N_REQ);
            if (!found && eligible[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chan_arbiter.sv
// N-way burst-limited round-robin arbiter feeding a one-entry registered output buffer.
module chan_arbiter
    import chan_arb_pkg::*;
#(
    parameter  int N_REQ     = DEF_N_REQ,
    parameter  int WIDTH     = DEF_WIDTH,
    parameter  int MAX_BURST = DEF_MAX_BURST,
    localparam int ID_W      = id_w(N_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [N_REQ-1:0]       enable_in,
    input  logic [N_REQ*WIDTH-1:0] data_in,
    output logic [N_REQ-1:0]       ready_out,
    input  logic [N_REQ-1:0]       mask_in,
    output logic [WIDTH-1:0]       data_out,
    output logic                   enable_out,
    output logic [ID_W-1:0]        grant_id_out,
    input  logic                   ready_in
);

    logic                 full;
    logic [ID_W-1:0]      last_grant;
    logic [7:0]           burst_cnt;

    logic [N_REQ-1:0]     eligible;
    logic                 sticky;
    logic [ID_W-1:0]      start;
    logic [N_REQ-1:0]     rr_grant;
    logic                 rr_found;
    logic [N_REQ-1:0]     win_oh;
    logic [ID_W-1:0]      win_id;
    logic [WIDTH-1:0]     win_data;
    logic                 have_win;
    logic                 accept;

    function automatic logic [ID_W-1:0] oh_to_id(input logic [N_REQ-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    assign eligible = enable_in & mask_in;
    assign sticky   = eligible[last_grant] && (burst_cnt != 8'd0) &&
                      (burst_cnt < 8'(MAX_BURST));
    // Search starts just past the previous owner so it is considered last.
    assign start    = (last_grant == ID_W'(N_REQ - 1)) ? '0 : last_grant + 1'b1;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .eligible (eligible),
        .start    (start),
        .grant    (rr_grant),
        .found    (rr_found)
    );

    assign win_oh   = sticky ? ({{(N_REQ-1){1'b0}}, 1'b1} << last_grant) : rr_grant;
    assign win_id   = oh_to_id(win_oh);
    assign have_win = sticky || rr_found;
    assign accept   = !full || ready_in;

    always_comb begin
        win_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win_oh[i]) win_data = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Gated by reset_n so no handshake is offered while the block is held in reset.
    assign ready_out  = (reset_n && accept) ? win_oh : '0;
    assign enable_out = full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            full         <= 1'b0;
            data_out     <= '0;
            grant_id_out <= '0;
            burst_cnt    <= 8'd0;
            last_grant   <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            if (have_win) begin
                data_out     <= win_data;
                grant_id_out <= win_id;
                full         <= 1'b1;
                last_grant   <= win_id;
                burst_cnt    <= sticky ? burst_cnt + 8'd1 : 8'd1;
            end else begin
                full      <= 1'b0;
                burst_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_chan_arbiter.sv
// Scoreboard bench for chan_arbiter with N_REQ=4, WIDTH=8, MAX_BURST=4.
module tb_chan_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   enable_in;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   ready_out;
    logic [N-1:0]   mask_in;
    logic [W-1:0]   data_out;
    logic           enable_out;
    logic [1:0]     grant_id_out;
    logic           ready_in;

    always #5 clk = ~clk;

    chan_arbiter #(
        .N_REQ     (4),
        .WIDTH     (8),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable_in    (enable_in),
        .data_in      (data_in),
        .ready_out    (ready_out),
        .mask_in      (mask_in),
        .data_out     (data_out),
        .enable_out   (enable_out),
        .grant_id_out (grant_id_out),
        .ready_in     (ready_in)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] base  [N];
    int         src_n [N];
    int         exp_n [N];
    exp_t       exp_q [$];
    bit         seen;

    // Each source presents base + number of its payloads already accepted.
    always_comb begin
        data_in = '0;
        for (int i = 0; i < N; i++) data_in[i*W +: W] = base[i] + 8'(src_n[i]);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, want);
        end
    endtask

    task automatic push_exp(input int id);
        exp_t e;
        e.id   = 2'(id);
        e.data = base[id] + 8'(exp_n[id]);
        exp_n[id]++;
        exp_q.push_back(e);
    endtask

    // One clock: observe at negedge, stop sources once the queue is empty, track handshakes.
    task automatic step();
        logic [N-1:0] hs;
        exp_t e;
        @(negedge clk);
        check_eq("ready_onehot", 32'($onehot0(ready_out)), 32'd1);
        if (seen && exp_q.size() > 0) check_eq("no_gap", 32'(enable_out), 32'd1);
        if (enable_out && ready_in) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                check_eq("extra_output", 32'(enable_out), 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("grant_id", 32'(grant_id_out), 32'(e.id));
                check_eq("data_out", 32'(data_out), 32'(e.data));
                if (exp_q.size() == 0) enable_in = '0;
            end
        end
        #1 hs = enable_in & ready_out;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) if (hs[i]) src_n[i]++;
    endtask

    task automatic run_until_empty(input int budget);
        int c;
        c = 0;
        while (exp_q.size() > 0 && c < budget) begin
            step();
            c++;
        end
        if (exp_q.size() > 0) check_eq("timeout_pending", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic apply_reset();
        reset_n   = 1'b0;
        enable_in = 4'hF;
        mask_in   = 4'hF;
        ready_in  = 1'b1;
        for (int i = 0; i < N; i++) base[i] = 8'($urandom);
        #1;
        check_eq("rst_enable_out", 32'(enable_out), 32'd0);
        check_eq("rst_data_out", 32'(data_out), 32'd0);
        check_eq("rst_grant_id", 32'(grant_id_out), 32'd0);
        check_eq("rst_ready_out", 32'(ready_out), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready_hold", 32'(ready_out), 32'd0);
        check_eq("rst_enable_hold", 32'(enable_out), 32'd0);
        exp_q.delete();
        seen = 1'b0;
        for (int i = 0; i < N; i++) begin
            src_n[i] = 0;
            exp_n[i] = 0;
            base[i]  = 8'(i * 16);
        end
        enable_in = '0;
        ready_in  = 1'b0;
        reset_n   = 1'b1;
    endtask

    initial begin
        // All requesting: bursts of four, rotating 0..3 then back to 0.
        apply_reset();
        enable_in = 4'hF;
        ready_in  = 1'b1;
        for (int g = 0; g < 17; g++) push_exp((g / 4) % 4);
        run_until_empty(18);

        // Lone requester 2 keeps winning across burst expiry with no bubble.
        apply_reset();
        base[2]   = 8'h10;
        enable_in = 4'b0100;
        ready_in  = 1'b1;
        for (int g = 0; g < 10; g++) push_exp(2);
        run_until_empty(11);

        // Back-pressure holds the buffer, then drain and refill in the same cycle.
        apply_reset();
        base[1]   = 8'hA5;
        enable_in = 4'b0010;
        ready_in  = 1'b0;
        step();
        for (int c = 0; c < 5; c++) begin
            check_eq("hold_enable_out", 32'(enable_out), 32'd1);
            check_eq("hold_data_out", 32'(data_out), 32'hA5);
            check_eq("hold_grant_id", 32'(grant_id_out), 32'd1);
            check_eq("hold_ready_out", 32'(ready_out), 32'd0);
            step();
        end
        push_exp(1);
        push_exp(1);
        ready_in = 1'b1;
        run_until_empty(3);

        // Requester 1 masked off: it never appears.
        apply_reset();
        mask_in   = 4'b1101;
        enable_in = 4'hF;
        ready_in  = 1'b1;
        for (int g = 0; g < 4; g++) push_exp(0);
        for (int g = 0; g < 4; g++) push_exp(2);
        for (int g = 0; g < 4; g++) push_exp(3);
        for (int g = 0; g < 4; g++) push_exp(0);
        run_until_empty(17);

        // Reset mid-burst of requester 1 discards everything; requester 0 wins afterwards.
        apply_reset();
        enable_in = 4'b0010;
        ready_in  = 1'b1;
        push_exp(1);
        push_exp(1);
        step();
        step();
        reset_n = 1'b0;
        #1;
        check_eq("midrst_enable_out", 32'(enable_out), 32'd0);
        check_eq("midrst_ready_out", 32'(ready_out), 32'd0);
        apply_reset();
        enable_in = 4'hF;
        ready_in  = 1'b1;
        for (int g = 0; g < 4; g++) push_exp(0);
        run_until_empty(5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
